// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// common
//   Shared types for the integer register file and its pending-write
//   scoreboard: scalar aliases, default sizes, the counter type and the
//   read-port request/response bundles used inside regfile_scoreboard.
// -----------------------------------------------------------------------------
package common;

   typedef logic [4:0]  u5;
   typedef logic [63:0] u64;

   localparam int NREG_C    = 32;
   localparam int REG_CNT_W = 2;

   typedef logic [REG_CNT_W-1:0] cnt_t;

   typedef struct packed {
      u5 ra1;
      u5 ra2;
   } RF_READ_REQ;

   typedef struct packed {
      u64   rd1;
      u64   rd2;
      logic busy1;
      logic busy2;
   } RF_READ_RSP;

endpackage

// File: rtl/regfile_scoreboard_cnt.sv
// -----------------------------------------------------------------------------
// rf_scoreboard_cnt
//   Per-register outstanding-writer counters. Decode increments a counter
//   when it reserves a destination; writeback decrements it. Produces the
//   issueReady and busy flags that decode uses for hazard stalls.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, busyN drops in the same cycle as the writeback that
//     retires the last outstanding writer of raN (unless raN is reserved
//     again in that cycle).
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   wbEn, wd            writeback strobe and destination
//   issueEn, issueRd    reservation strobe and destination
//   issueReady          0 when the issueRd counter is saturated
//   flush               clears every counter
//   ra1, ra2            read addresses being checked for hazards
//   busy1, busy2        read address has an outstanding writer
// -----------------------------------------------------------------------------
module rf_scoreboard_cnt
   import common::*;
#(
   parameter int NREG  = NREG_C,
   parameter int CNT_W = REG_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wbEn,
   input  logic [4:0] wd,
   input  logic       issueEn,
   input  logic [4:0] issueRd,
   input  logic       flush,
   input  logic [4:0] ra1,
   input  logic [4:0] ra2,
   output logic       issueReady,
   output logic       busy1,
   output logic       busy2
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt [NREG];
   logic [NREG-1:0]  w_inc;
   logic [NREG-1:0]  w_dec;
   logic             w_issue_ready;
   logic             w_issue_go;
   logic             w_busy1_raw;
   logic             w_busy2_raw;

   assign w_issue_ready = (issueRd == 5'd0) || (r_cnt[issueRd] != CNT_MAX);
   assign w_issue_go    = issueEn && w_issue_ready;
   assign issueReady    = w_issue_ready;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a bit unassigned and no latch is inferred.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int r = 1; r < NREG; r++) begin
         w_inc[r] = w_issue_go && (issueRd == 5'(r));
         // A writeback at cnt==0 is stale (its reservation was flushed).
         w_dec[r] = wbEn && (wd == 5'(r)) && (r_cnt[r] != '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // counter sees the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      end else if (flush) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      end else begin
         // Entry 0 is never touched after reset, so x0 never looks busy.
         for (int r = 1; r < NREG; r++) begin
            case ({w_inc[r], w_dec[r]})
               2'b10:   r_cnt[r] <= r_cnt[r] + CNT_ONE;
               2'b01:   r_cnt[r] <= r_cnt[r] - CNT_ONE;
               default: r_cnt[r] <= r_cnt[r];
            endcase
         end
      end
   end

   assign w_busy1_raw = (ra1 != 5'd0) && (r_cnt[ra1] != '0);
   assign w_busy2_raw = (ra2 != 5'd0) && (r_cnt[ra2] != '0);

`ifdef REGFILE_BYPASS_EN
   // The value is forwarded this cycle, so the hazard clears as soon as the
   // last writer retires, unless a new writer is reserved at the same edge.
   assign busy1 = w_busy1_raw &&
                  !(wbEn && (wd == ra1) && (r_cnt[ra1] == CNT_ONE) && !w_inc[ra1]);
   assign busy2 = w_busy2_raw &&
                  !(wbEn && (wd == ra2) && (r_cnt[ra2] == CNT_ONE) && !w_inc[ra2]);
`else
   assign busy1 = w_busy1_raw;
   assign busy2 = w_busy2_raw;
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   32x64 integer register file with a pending-write scoreboard. Writeback
//   commits results at the clock edge; two combinational read ports serve
//   decode together with per-port busy flags. x0 reads as zero and ignores
//   writes.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, a writeback to raN is forwarded to rdN in the same cycle.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   wbEn, wd, wbData    writeback strobe, destination, data
//   ra1, ra2            read addresses
//   rd1, rd2            read data (combinational)
//   busy1, busy2        read address has an outstanding writer
//   issueEn, issueRd    decode reserves issueRd
//   issueReady          issueRd can accept another reservation
//   flush               clears every outstanding-writer counter
// -----------------------------------------------------------------------------
module regfile_scoreboard
   import common::*;
#(
   parameter int NREG  = NREG_C,
   parameter int CNT_W = REG_CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbEn,
   input  logic [4:0]  wd,
   input  logic [63:0] wbData,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [63:0] rd1,
   output logic [63:0] rd2,
   output logic        busy1,
   output logic        busy2,
   input  logic        issueEn,
   input  logic [4:0]  issueRd,
   output logic        issueReady,
   input  logic        flush
);

   logic [63:0] r_regs [NREG];
   RF_READ_REQ  w_req;
   RF_READ_RSP  w_rsp;
   logic        w_busy1;
   logic        w_busy2;

   // NOTE: the storage array is reset explicitly because architectural state
   // must read as zero after reset; this forces flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      end else if (wbEn && (wd != 5'd0)) begin
         r_regs[wd] <= wbData;
      end
   end

   rf_scoreboard_cnt #(
      .NREG  (NREG),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .wbEn       (wbEn),
      .wd         (wd),
      .issueEn    (issueEn),
      .issueRd    (issueRd),
      .flush      (flush),
      .ra1        (w_req.ra1),
      .ra2        (w_req.ra2),
      .issueReady (issueReady),
      .busy1      (w_busy1),
      .busy2      (w_busy2)
   );

   assign w_req.ra1 = ra1;
   assign w_req.ra2 = ra2;

   always_comb begin
      w_rsp       = '0;
      w_rsp.rd1   = (w_req.ra1 == 5'd0) ? 64'd0 : r_regs[w_req.ra1];
      w_rsp.rd2   = (w_req.ra2 == 5'd0) ? 64'd0 : r_regs[w_req.ra2];
`ifdef REGFILE_BYPASS_EN
      if (wbEn && (wd == w_req.ra1) && (w_req.ra1 != 5'd0)) w_rsp.rd1 = wbData;
      if (wbEn && (wd == w_req.ra2) && (w_req.ra2 != 5'd0)) w_rsp.rd2 = wbData;
`endif
      w_rsp.busy1 = w_busy1;
      w_rsp.busy2 = w_busy2;
   end

   assign rd1   = w_rsp.rd1;
   assign rd2   = w_rsp.rd2;
   assign busy1 = w_rsp.busy1;
   assign busy2 = w_rsp.busy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Table-driven bench for regfile_scoreboard. Each table row holds one
//   cycle of inputs and the combinational outputs expected during that cycle
//   (before the edge commits it). Expectations are queued when a row is
//   driven and popped at the following negedge for comparison.
//   Honours REGFILE_BYPASS_EN by patching the rows whose visible outputs
//   change with forwarding.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic        wbEn;
   logic [4:0]  wd;
   logic [63:0] wbData;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [63:0] rd1;
   logic [63:0] rd2;
   logic        busy1;
   logic        busy2;
   logic        issueEn;
   logic [4:0]  issueRd;
   logic        issueReady;
   logic        flush;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        wb_en;
      logic [4:0]  wd;
      logic [63:0] wb_data;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        iss_en;
      logic [4:0]  iss_rd;
      logic        flush;
      logic [63:0] e_rd1;
      logic [63:0] e_rd2;
      logic        e_b1;
      logic        e_b2;
      logic        e_rdy;
   } vec_t;

   localparam int NVEC = 21;
   localparam logic [63:0] D = 64'hDEAD_BEEF_0123_4567;

   vec_t vecs [NVEC];
   vec_t exp_q [$];

   regfile_scoreboard dut (
      .clk        (clk),
      .rst        (rst),
      .wbEn       (wbEn),
      .wd         (wd),
      .wbData     (wbData),
      .ra1        (ra1),
      .ra2        (ra2),
      .rd1        (rd1),
      .rd2        (rd2),
      .busy1      (busy1),
      .busy2      (busy2),
      .issueEn    (issueEn),
      .issueRd    (issueRd),
      .issueReady (issueReady),
      .flush      (flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      wbEn    = v.wb_en;
      wd      = v.wd;
      wbData  = v.wb_data;
      ra1     = v.ra1;
      ra2     = v.ra2;
      issueEn = v.iss_en;
      issueRd = v.iss_rd;
      flush   = v.flush;
      exp_q.push_back(v);
   endtask

   task automatic compare_next(input string tag);
      vec_t e;
      e = exp_q.pop_front();
      check({tag, ".rd1"},   rd1,        e.e_rd1);
      check({tag, ".rd2"},   rd2,        e.e_rd2);
      check({tag, ".busy1"}, 64'(busy1), 64'(e.e_b1));
      check({tag, ".busy2"}, 64'(busy2), 64'(e.e_b2));
      check({tag, ".ready"}, 64'(issueReady), 64'(e.e_rdy));
   endtask

   task automatic idle();
      wbEn = 1'b0; wd = '0; wbData = '0; ra1 = '0; ra2 = '0;
      issueEn = 1'b0; issueRd = '0; flush = 1'b0;
   endtask

   initial begin
      //          wb wd  data            ra1 ra2 ie ird fl  e_rd1           e_rd2  b1 b2 rdy
      vecs[0]  = '{1, 5, D,              5,  0,  0, 0,  0,  64'd0,          64'd0, 0, 0, 1};
      vecs[1]  = '{1, 0, 64'hFFFF,       5,  0,  1, 0,  0,  D,              64'd0, 0, 0, 1};
      vecs[2]  = '{0, 0, 64'd0,          0,  0,  0, 0,  0,  64'd0,          64'd0, 0, 0, 1};
      vecs[3]  = '{0, 0, 64'd0,          7,  5,  1, 7,  0,  64'd0,          D,     0, 0, 1};
      vecs[4]  = '{0, 0, 64'd0,          7,  0,  1, 7,  0,  64'd0,          64'd0, 1, 0, 1};
      vecs[5]  = '{0, 0, 64'd0,          7,  0,  1, 7,  0,  64'd0,          64'd0, 1, 0, 1};
      vecs[6]  = '{0, 0, 64'd0,          7,  0,  1, 7,  0,  64'd0,          64'd0, 1, 0, 0};
      vecs[7]  = '{1, 7, 64'h1111,       7,  0,  0, 7,  0,  64'd0,          64'd0, 1, 0, 0};
      vecs[8]  = '{1, 7, 64'h2222,       7,  0,  0, 7,  0,  64'h1111,       64'd0, 1, 0, 1};
      vecs[9]  = '{1, 7, 64'h3333,       7,  0,  0, 7,  0,  64'h2222,       64'd0, 1, 0, 1};
      vecs[10] = '{0, 0, 64'd0,          7,  0,  0, 0,  0,  64'h3333,       64'd0, 0, 0, 1};
      vecs[11] = '{0, 0, 64'd0,          9,  0,  1, 9,  0,  64'd0,          64'd0, 0, 0, 1};
      vecs[12] = '{1, 9, 64'h9999,       9,  0,  1, 9,  0,  64'd0,          64'd0, 1, 0, 1};
      vecs[13] = '{0, 0, 64'd0,          9,  0,  0, 9,  0,  64'h9999,       64'd0, 1, 0, 1};
      vecs[14] = '{0, 0, 64'd0,          3,  9,  1, 3,  0,  64'd0,          64'h9999, 0, 1, 1};
      vecs[15] = '{0, 0, 64'd0,          3,  9,  0, 0,  1,  64'd0,          64'h9999, 1, 1, 1};
      vecs[16] = '{1, 3, 64'h3030,       3,  9,  0, 0,  0,  64'd0,          64'h9999, 0, 0, 1};
      vecs[17] = '{0, 0, 64'd0,          3,  9,  1, 3,  0,  64'h3030,       64'h9999, 0, 0, 1};
      vecs[18] = '{0, 0, 64'd0,          3,  0,  0, 0,  0,  64'h3030,       64'd0, 1, 0, 1};
      vecs[19] = '{1, 3, 64'h4040,       3,  0,  0, 0,  1,  64'h3030,       64'd0, 1, 0, 1};
      vecs[20] = '{0, 0, 64'd0,          3,  0,  0, 3,  0,  64'h4040,       64'd0, 0, 0, 1};
`ifdef REGFILE_BYPASS_EN
      vecs[0].e_rd1  = D;
      vecs[7].e_rd1  = 64'h1111;
      vecs[8].e_rd1  = 64'h2222;
      vecs[9].e_rd1  = 64'h3333;
      vecs[9].e_b1   = 1'b0;
      vecs[12].e_rd1 = 64'h9999;
      vecs[16].e_rd1 = 64'h3030;
      vecs[19].e_rd1 = 64'h4040;
      vecs[19].e_b1  = 1'b0;
`endif

      // Reset held for two edges, then every register reads clear.
      rst = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ra1     = 5'(i);
         ra2     = 5'(31 - i);
         issueRd = 5'(i);
         @(negedge clk);
         check($sformatf("reset.rd1[%0d]", i), rd1, 64'd0);
         check($sformatf("reset.busy1[%0d]", i), 64'(busy1), 64'd0);
         check($sformatf("reset.rd2[%0d]", 31 - i), rd2, 64'd0);
         check($sformatf("reset.ready[%0d]", i), 64'(issueReady), 64'd1);
         @(posedge clk);
         #1;
      end

      // Main table: one row per cycle.
      for (int i = 0; i < NVEC; i++) begin
         drive_vec(vecs[i]);
         @(negedge clk);
         compare_next($sformatf("vec%0d", i));
         @(posedge clk);
         #1;
      end

      // Reset in the middle of traffic: write, issue and flush are all
      // overridden, and previously written registers read clear.
      idle();
      rst     = 1'b0;
      wbEn    = 1'b1;
      wd      = 5'd5;
      wbData  = 64'hABCD;
      issueEn = 1'b1;
      issueRd = 5'd5;
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_vec('{0, 0, 64'd0, 5, 9, 0, 5, 0, 64'd0, 64'd0, 0, 0, 1});
      @(negedge clk);
      compare_next("midreset");
      @(posedge clk);
      #1;

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
